// File: rtl/mm_pkg.sv
// Shared types and sizing helpers for the sequential matrix multiplier.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mm_state_t;

    localparam int MM_IDX_W_MIN = 1;

    // Smallest result width that holds a full N-term dot product of W-bit operands.
    function automatic int mm_min_rw(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

    function automatic int mm_idx_w(input int n);
        return ($clog2(n) < MM_IDX_W_MIN) ? MM_IDX_W_MIN : $clog2(n);
    endfunction

endpackage

// File: rtl/mm_mac.sv
// Unsigned W x W multiply with an RW-bit registered accumulator.
module mm_mac
    import mm_pkg::*;
#(
    parameter int W  = 8,
    parameter int RW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [RW-1:0] sum
);

    logic [RW-1:0]  acc_q;
    logic [2*W-1:0] prod;

    assign prod = (2*W)'(a) * (2*W)'(b);
    // clear restarts the dot product in the same cycle as its first term
    assign sum  = (clear ? '0 : acc_q) + RW'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end else if (clear) begin
            acc_q <= '0;
        end
    end

endmodule

// File: rtl/seq_matrix_mult.sv
// Sequential N x N unsigned matrix multiplier, one multiply-accumulate per clock.
//   state | meaning
//   IDLE  | waiting for start; operands latched on the accepting edge
//   CALC  | stepping k (fastest), j, i through all N^3 products
//   DONE  | one-cycle done pulse; outputs already hold the new result
module seq_matrix_mult
    import mm_pkg::*;
#(
    parameter int N  = 2,
    parameter int W  = 8,
    parameter int RW = 2 * W + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*N*W-1:0]  a_flat,
    input  logic [N*N*W-1:0]  b_flat,
    output logic              busy,
    output logic              done,
    output logic [N*N*RW-1:0] res_flat,
    output logic [N*N-1:0]    ovf
);

    if (N < 2) begin : g_bad_n
        $error("seq_matrix_mult: N must be at least 2");
    end
    if (RW < mm_min_rw(N, W)) begin : g_bad_rw
        $error("seq_matrix_mult: RW too small for full-precision results");
    end

    localparam int             IW   = mm_idx_w(N);
    localparam logic [IW-1:0]  LAST = IW'(N - 1);

    mm_state_t      state_q, state_d;
    logic [IW-1:0]  i_q, j_q, k_q;
    logic [W-1:0]   a_m [N][N];
    logic [W-1:0]   b_m [N][N];
    logic [RW-1:0]  shd [N][N];
    logic           shd_ovf [N][N];
    logic           load, step, mac_clear, mac_en;
    logic           k_last, last_step, sum_ovf;
    logic [RW-1:0]  mac_sum;

    assign k_last    = (k_q == LAST);
    assign last_step = k_last && (j_q == LAST) && (i_q == LAST);
    assign sum_ovf   = |mac_sum[RW-1:W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    mac_clear = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                busy      = 1'b1;
                step      = 1'b1;
                mac_en    = 1'b1;
                mac_clear = (k_q == '0);
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mm_mac #(.W(W), .RW(RW)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (a_m[i_q][k_q]),
        .b     (b_m[k_q][j_q]),
        .sum   (mac_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            res_flat <= '0;
            ovf      <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_m[r][c]     <= '0;
                    b_m[r][c]     <= '0;
                    shd[r][c]     <= '0;
                    shd_ovf[r][c] <= 1'b0;
                end
            end
        end else begin
            if (load) begin
                i_q <= '0;
                j_q <= '0;
                k_q <= '0;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        a_m[r][c] <= a_flat[(N*N-1-(r*N+c))*W +: W];
                        b_m[r][c] <= b_flat[(N*N-1-(r*N+c))*W +: W];
                    end
                end
            end
            if (step) begin
                if (k_last) begin
                    k_q               <= '0;
                    shd[i_q][j_q]     <= mac_sum;
                    shd_ovf[i_q][j_q] <= sum_ovf;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end else begin
                    k_q <= k_q + 1'b1;
                end
                // Publish the whole matrix at once; the final element bypasses the shadow.
                if (last_step) begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            if (r == N - 1 && c == N - 1) begin
                                res_flat[(N*N-1-(r*N+c))*RW +: RW] <= mac_sum;
                                ovf[N*N-1-(r*N+c)]                 <= sum_ovf;
                            end else begin
                                res_flat[(N*N-1-(r*N+c))*RW +: RW] <= shd[r][c];
                                ovf[N*N-1-(r*N+c)]                 <= shd_ovf[r][c];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_matrix_mult.sv
// Bench for seq_matrix_mult: N=2/W=8 and N=3/W=4 instances against a plain matrix-product model.
module tb_seq_matrix_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start2, busy2, done2;
    logic [31:0] a2, b2;
    logic [67:0] res2;
    logic [3:0]  ovf2;

    logic        start3, busy3, done3;
    logic [35:0] a3, b3;
    logic [89:0] res3;
    logic [8:0]  ovf3;

    int compared   = 0;
    int mismatched = 0;

    seq_matrix_mult #(.N(2), .W(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_flat(a2), .b_flat(b2),
        .busy(busy2), .done(done2), .res_flat(res2), .ovf(ovf2)
    );

    seq_matrix_mult #(.N(3), .W(4)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_flat(a3), .b_flat(b3),
        .busy(busy3), .done(done3), .res_flat(res3), .ovf(ovf3)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pack(input int n, input int w, input int m[9]);
        logic [71:0] v;
        v = '0;
        for (int e = 0; e < n * n; e++) begin
            v = (v << w) | 72'(m[e] & ((1 << w) - 1));
        end
        return v;
    endfunction

    // Reference: unpack to integer matrices, multiply, repack; ovf where the element exceeds 2^w-1.
    function automatic void ref_mm(input int n, input int w, input int rw,
                                   input logic [71:0] af, input logic [71:0] bf,
                                   output logic [127:0] rf, output logic [127:0] of);
        int          am[9];
        int          bm[9];
        longint      s;
        logic [71:0] t;
        for (int e = 0; e < n * n; e++) begin
            t     = af >> ((n * n - 1 - e) * w);
            am[e] = int'(t[15:0]) & ((1 << w) - 1);
            t     = bf >> ((n * n - 1 - e) * w);
            bm[e] = int'(t[15:0]) & ((1 << w) - 1);
        end
        rf = '0;
        of = '0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += longint'(am[r*n+k]) * longint'(bm[k*n+c]);
                rf |= 128'(s) << ((n * n - 1 - (r * n + c)) * rw);
                if (s >= (longint'(1) << w)) of[n*n-1-(r*n+c)] = 1'b1;
            end
        end
    endfunction

    task automatic run2(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [127:0] er, eo;
        int busy_n, ndone, done_at;
        ref_mm(2, 8, 17, 72'(a), 72'(b), er, eo);
        busy_n = 0; ndone = 0; done_at = -1;
        @(negedge clk); a2 = a; b2 = b; start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0; a2 = $urandom(); b2 = $urandom();
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (busy2) busy_n++;
            if (done2) begin ndone++; if (done_at < 0) done_at = c; end
            if (c == 4) begin a2 = $urandom(); b2 = $urandom(); end
        end
        chk({tag, "_busy_cycles"}, 128'(busy_n), 128'(8));
        chk({tag, "_done_count"}, 128'(ndone), 128'(1));
        chk({tag, "_latency"}, 128'(done_at), 128'(9));
        chk({tag, "_res"}, 128'(res2), er);
        chk({tag, "_ovf"}, 128'(ovf2), eo);
    endtask

    task automatic run3(input string tag, input logic [35:0] a, input logic [35:0] b);
        logic [127:0] er, eo;
        int busy_n, ndone, done_at;
        ref_mm(3, 4, 10, 72'(a), 72'(b), er, eo);
        busy_n = 0; ndone = 0; done_at = -1;
        @(negedge clk); a3 = a; b3 = b; start3 = 1'b1;
        @(posedge clk); #1; start3 = 1'b0; a3 = {4'($urandom()), $urandom()};
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy3) busy_n++;
            if (done3) begin ndone++; if (done_at < 0) done_at = c; end
            if (c == 10) b3 = {4'($urandom()), $urandom()};
        end
        chk({tag, "_busy_cycles"}, 128'(busy_n), 128'(27));
        chk({tag, "_done_count"}, 128'(ndone), 128'(1));
        chk({tag, "_latency"}, 128'(done_at), 128'(28));
        chk({tag, "_res"}, 128'(res3), er);
        chk({tag, "_ovf"}, 128'(ovf3), eo);
    endtask

    initial begin
        logic [31:0]  ahist[$];
        logic [127:0] er, eo;
        logic [35:0]  id3, seq3;
        int m;

        rst = 1'b1; start2 = 1'b0; start3 = 1'b0;
        a2 = '0; b2 = '0; a3 = '0; b3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy2", 128'(busy2), 128'(0));
        chk("rst_done2", 128'(done2), 128'(0));
        chk("rst_res2", 128'(res2), 128'(0));
        chk("rst_ovf2", 128'(ovf2), 128'(0));
        chk("rst_busy3", 128'(busy3), 128'(0));
        chk("rst_res3", 128'(res3), 128'(0));
        rst = 1'b0;

        run2("n2_basic", 32'h01020304, 32'h05060708);
        chk("n2_basic_known", 128'(res2), 128'({17'd19, 17'd22, 17'd43, 17'd50}));
        run2("n2_max", 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("n2_max_known", 128'(res2), 128'({4{17'd130050}}));
        chk("n2_max_ovf_known", 128'(ovf2), 128'(4'b1111));
        for (int t = 0; t < 3; t++) run2($sformatf("n2_rand%0d", t), $urandom(), $urandom());

        id3  = 36'(pack(3, 4, '{1, 0, 0, 0, 1, 0, 0, 0, 1}));
        seq3 = 36'(pack(3, 4, '{1, 2, 3, 4, 5, 6, 7, 8, 9}));
        run3("n3_ident", id3, seq3);
        chk("n3_ident_known", 128'(res3),
            128'({10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8, 10'd9}));
        run3("n3_max", {9{4'hF}}, {9{4'hF}});
        chk("n3_max_known", 128'(res3), 128'({9{10'd675}}));
        chk("n3_max_ovf_known", 128'(ovf3), 128'(9'h1FF));
        for (int t = 0; t < 2; t++)
            run3($sformatf("n3_rand%0d", t), {4'($urandom()), $urandom()}, {4'($urandom()), $urandom()});

        // start held high while a_flat changes every cycle: one accepted start per 10 cycles
        @(negedge clk);
        b2 = $urandom(); a2 = $urandom(); start2 = 1'b1;
        ahist.push_back(a2);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            m = c % 10;
            chk($sformatf("cont_busy_c%0d", c), 128'(busy2), 128'(m <= 7));
            chk($sformatf("cont_done_c%0d", c), 128'(done2), 128'(m == 8));
            if (m == 8) begin
                ref_mm(2, 8, 17, 72'(ahist[c-8]), 72'(b2), er, eo);
                chk($sformatf("cont_res_c%0d", c), 128'(res2), er);
                chk($sformatf("cont_ovf_c%0d", c), 128'(ovf2), eo);
            end
            a2 = $urandom();
            ahist.push_back(a2);
        end
        start2 = 1'b0;
        repeat (12) @(negedge clk);

        // abort in the 4th CALC cycle
        run2("pre_abort", 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk); a2 = $urandom(); b2 = $urandom(); start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", 128'(busy2), 128'(1));
        rst = 1'b1;
        #1;
        chk("abort_busy", 128'(busy2), 128'(0));
        chk("abort_done", 128'(done2), 128'(0));
        chk("abort_res", 128'(res2), 128'(0));
        chk("abort_ovf", 128'(ovf2), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run2("post_abort", 32'h01020304, 32'h05060708);
        chk("post_abort_known", 128'(res2), 128'({17'd19, 17'd22, 17'd43, 17'd50}));
        run2("post_abort_rand", $urandom(), $urandom());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
